// File: rtl/flash_boot_loader_pkg.sv
// Shared types and constants for the flash boot loader.
package flash_boot_loader_pkg;

    // Boot sequencer states.
    typedef enum logic [2:0] {
        ST_INIT,
        ST_LOAD_CMD,
        ST_LOAD_ADDR,
        ST_SEND,
        ST_READ_DATA,
        ST_START_WRITE,
        ST_WRITE,
        ST_DONE
    } state_e;

    // SPI flash READ opcode.
    localparam logic [7:0] FlashCmdRead = 8'h03;

    // Bytes packed into one RAM word.
    localparam int WordBytes = 4;

endpackage

// File: rtl/flash_boot_loader_spi_bit_shifter.sv
// MSB-first SPI shift register with bit counter and clock phase toggle.
// Each bit takes two cycles: low phase (sclk=0, mosi valid), then high
// phase (sclk=1) at whose end miso is shifted in and the count drops.
module spi_bit_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [23:0] load_data,
    input  logic [4:0]  load_bits,
    input  logic        shift_en,
    input  logic        miso,
    output logic        sclk,
    output logic        mosi,
    output logic        last_bit,
    output logic [7:0]  rx_byte
);

    logic [23:0] sr_q, sr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        phase_q, phase_d;

    // Load has priority; otherwise advance one half bit period when enabled.
    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (load) begin
            sr_d    = load_data;
            cnt_d   = load_bits;
            phase_d = 1'b0;
        end else if (shift_en && (cnt_q != 5'd0)) begin
            if (!phase_q) begin
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                sr_d    = {sr_q[22:0], miso};
                cnt_d   = cnt_q - 5'd1;
            end
        end
    end

    // Shift register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign sclk     = phase_q;
    assign mosi     = sr_q[23];
    // High phase of the final bit: the caller may move on this cycle.
    assign last_bit = shift_en && phase_q && (cnt_q == 5'd1);
    // Byte completed by the bit being sampled this cycle.
    assign rx_byte  = {sr_q[6:0], miso};

endmodule

// File: rtl/flash_boot_loader.sv
// Boot stage: reads an image from SPI flash and stores it word by word
// through the ramio request port, then raises a sticky done.
module flash_boot_loader
    import flash_boot_loader_pkg::*;
#(
    parameter logic [31:0] TransferByteCount = 32'h0000_0100,
    parameter logic [23:0] FlashStartAddress = 24'h00_0000,
    parameter int unsigned StartupWaitCycles = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        flash_clk,
    output logic        flash_mosi,
    input  logic        flash_miso,
    output logic        flash_cs_n,
    output logic        enable,
    output logic [1:0]  write_type,
    output logic [2:0]  read_type,
    output logic [31:0] address,
    output logic [31:0] data_in,
    input  logic        busy,
    output logic        done
);

    localparam logic [31:0] WaitLimit = StartupWaitCycles;

    state_e      state_q, state_d, ret_q, ret_d;
    logic [31:0] wait_q, wait_d;
    logic [31:0] ptr_q, ptr_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic        enable_q, enable_d;
    logic [1:0]  write_type_q, write_type_d;
    logic [31:0] address_q, address_d;
    logic [31:0] data_in_q, data_in_d;
    logic        cs_n_q, cs_n_d;
    logic        done_q, done_d;

    logic        sh_load, sh_shift, sh_last;
    logic [23:0] sh_data;
    logic [4:0]  sh_bits;
    logic [7:0]  sh_rx;

    spi_bit_shifter u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sh_load),
        .load_data(sh_data),
        .load_bits(sh_bits),
        .shift_en (sh_shift),
        .miso     (flash_miso),
        .sclk     (flash_clk),
        .mosi     (flash_mosi),
        .last_bit (sh_last),
        .rx_byte  (sh_rx)
    );

    // Sequencer next state and shifter control.
    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        wait_d       = wait_q;
        ptr_d        = ptr_q;
        word_d       = word_q;
        byte_idx_d   = byte_idx_q;
        enable_d     = enable_q;
        write_type_d = write_type_q;
        address_d    = address_q;
        data_in_d    = data_in_q;
        cs_n_d       = cs_n_q;
        done_d       = done_q;
        sh_load      = 1'b0;
        sh_shift     = 1'b0;
        sh_data      = '0;
        sh_bits      = '0;
        unique case (state_q)
            ST_INIT: begin
                if (wait_q + 32'd1 >= WaitLimit) state_d = ST_LOAD_CMD;
                else wait_d = wait_q + 32'd1;
            end
            ST_LOAD_CMD: begin
                cs_n_d  = 1'b0;
                sh_load = 1'b1;
                sh_data = {FlashCmdRead, 16'h0000};
                sh_bits = 5'd8;
                ret_d   = ST_LOAD_ADDR;
                state_d = ST_SEND;
            end
            ST_LOAD_ADDR: begin
                sh_load = 1'b1;
                sh_data = FlashStartAddress;
                sh_bits = 5'd24;
                ret_d   = ST_READ_DATA;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                sh_shift = 1'b1;
                if (sh_last) begin
                    state_d = ret_q;
                    // Arm the first data byte so ReadData starts shifting at once.
                    if (ret_q == ST_READ_DATA) begin
                        sh_load = 1'b1;
                        sh_bits = 5'd8;
                    end
                end
            end
            ST_READ_DATA: begin
                sh_shift = 1'b1;
                if (sh_last) begin
                    word_d[{byte_idx_q, 3'b000} +: 8] = sh_rx;
                    byte_idx_d = byte_idx_q + 2'd1;
                    // Re-arm for the next byte; stays parked while stalled.
                    sh_load = 1'b1;
                    sh_bits = 5'd8;
                    if (byte_idx_q == 2'd3) state_d = ST_START_WRITE;
                end
            end
            ST_START_WRITE: begin
                if (!busy) begin
                    enable_d     = 1'b1;
                    write_type_d = 2'b11;
                    address_d    = ptr_q;
                    data_in_d    = word_q;
                    ptr_d        = ptr_q + 32'(WordBytes);
                    state_d      = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!busy) begin
                    enable_d     = 1'b0;
                    write_type_d = 2'b00;
                    if (ptr_q < TransferByteCount) begin
                        state_d = ST_READ_DATA;
                    end else begin
                        cs_n_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Sequencer state and registered ramio/flash outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            ret_q        <= ST_INIT;
            wait_q       <= '0;
            ptr_q        <= '0;
            word_q       <= '0;
            byte_idx_q   <= '0;
            enable_q     <= 1'b0;
            write_type_q <= '0;
            address_q    <= '0;
            data_in_q    <= '0;
            cs_n_q       <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            wait_q       <= wait_d;
            ptr_q        <= ptr_d;
            word_q       <= word_d;
            byte_idx_q   <= byte_idx_d;
            enable_q     <= enable_d;
            write_type_q <= write_type_d;
            address_q    <= address_d;
            data_in_q    <= data_in_d;
            cs_n_q       <= cs_n_d;
            done_q       <= done_d;
        end
    end

    assign flash_cs_n = cs_n_q;
    assign enable     = enable_q;
    assign write_type = write_type_q;
    assign read_type  = 3'b000;
    assign address    = address_q;
    assign data_in    = data_in_q;
    assign done       = done_q;

endmodule

// File: tb/tb_flash_boot_loader.sv
// Bench for flash_boot_loader: SPI flash image model, ramio memory model
// with a write scoreboard, and a second small-transfer instance.
module tb_flash_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic        flash_clk, flash_mosi, flash_miso, flash_cs_n, enable, done;
    logic [1:0]  write_type;
    logic [2:0]  read_type;
    logic [31:0] address, data_in;

    logic        s_flash_clk, s_flash_mosi, s_flash_cs_n, s_enable, s_done;
    logic [1:0]  s_write_type;
    logic [2:0]  s_read_type;
    logic [31:0] s_address, s_data_in;

    int checks = 0;
    int passed = 0;

    logic [63:0] exp_q[$];
    logic [63:0] sb_exp;
    logic [7:0]  img [256];
    logic [7:0]  mem [256];
    int          bit_cnt, served, pulses, s_pulses;
    int          cyc = 0;
    int          hi_stamp [32];
    logic [31:0] cmd_bits;
    logic [31:0] s_last_addr, s_last_data;
    logic [1:0]  s_last_wt;

    localparam logic [79:0] ResetOuts = 80'({1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b0});

    always #5 clk = ~clk;

    flash_boot_loader #(
        .TransferByteCount(32'h0000_0100),
        .FlashStartAddress(24'h00_0000),
        .StartupWaitCycles(10)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .flash_clk(flash_clk), .flash_mosi(flash_mosi), .flash_miso(flash_miso),
        .flash_cs_n(flash_cs_n), .enable(enable), .write_type(write_type),
        .read_type(read_type), .address(address), .data_in(data_in),
        .busy(busy), .done(done)
    );

    flash_boot_loader #(
        .TransferByteCount(32'h0000_0004),
        .FlashStartAddress(24'h00_0000),
        .StartupWaitCycles(3)
    ) dut_small (
        .clk(clk), .rst_n(rst_n),
        .flash_clk(s_flash_clk), .flash_mosi(s_flash_mosi), .flash_miso(1'b1),
        .flash_cs_n(s_flash_cs_n), .enable(s_enable), .write_type(s_write_type),
        .read_type(s_read_type), .address(s_address), .data_in(s_data_in),
        .busy(1'b0), .done(s_done)
    );

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] word_of(input int w);
        return {img[(4*w+3)%256], img[(4*w+2)%256], img[(4*w+1)%256], img[(4*w)%256]};
    endfunction

    function automatic logic [79:0] outs();
        return 80'({flash_clk, flash_mosi, flash_cs_n, enable, write_type, read_type,
                    address, data_in, done});
    endfunction

    function automatic int mem_errors();
        int e;
        e = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== img[i]) e++;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Flash model: data bit presented while the DUT samples on the high phase.
    always_comb begin
        int idx;
        idx = 0;
        flash_miso = 1'b0;
        if (bit_cnt >= 32) begin
            idx = bit_cnt - 32;
            flash_miso = img[(idx / 8) % 256][7 - (idx % 8)];
        end
    end

    // Flash model: capture command/address, push expected words as served.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 0;
            served  <= 0;
            exp_q.delete();
        end else if (flash_cs_n) begin
            bit_cnt <= 0;
        end else if (flash_clk) begin
            if (bit_cnt < 32) begin
                cmd_bits <= {cmd_bits[30:0], flash_mosi};
                hi_stamp[bit_cnt] <= cyc;
            end else if (((bit_cnt - 32) % 32) == 31) begin
                exp_q.push_back({32'(served * 4), word_of(served)});
                served <= served + 1;
            end
            bit_cnt <= bit_cnt + 1;
        end
    end

    // ramio model: check each write strobe against the scoreboard and store it.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulses = 0;
            for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        end else if (enable) begin
            sb_exp = (exp_q.size() != 0) ? exp_q.pop_front() : {64{1'b1}};
            check("ramio_write", 80'({write_type, read_type, address, data_in}),
                  80'({2'b11, 3'b000, sb_exp}));
            for (int b = 0; b < 4; b++) mem[address[7:0] + 8'(b)] = data_in[8*b +: 8];
            pulses = pulses + 1;
        end
    end

    // Small instance write monitor.
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_pulses = 0;
        end else if (s_enable) begin
            s_pulses    = s_pulses + 1;
            s_last_addr = s_address;
            s_last_data = s_data_in;
            s_last_wt   = s_write_type;
        end
    end

    initial begin
        int n;
        int bad;
        busy = 1'b0;
        for (int i = 0; i < 256; i++) img[i] = 8'($urandom_range(0, 255));
        img[16] = 8'hC4; img[17] = 8'hA9; img[18] = 8'hB8; img[19] = 8'hD5;

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", outs(), ResetOuts);
        rst_n = 1'b1;

        // Command and address on mosi.
        n = 0;
        while (flash_cs_n && n < 200) begin @(posedge clk); #1; n++; end
        check("cs_n_fall", 80'(flash_cs_n), 80'(0));
        n = 0;
        while (bit_cnt < 33 && n < 300) begin @(posedge clk); #1; n++; end
        check("cmd_addr_bits", 80'(cmd_bits), 80'(32'h0300_0000));
        bad = 0;
        for (int i = 1; i < 32; i++)
            if (i != 8 && (hi_stamp[i] - hi_stamp[i-1]) != 2) bad++;
        check("bit_period", 80'(bad), 80'(0));

        // Stall ramio while the loader waits in StartWrite for word 6.
        n = 0;
        while (served < 7 && n < 2000) begin @(posedge clk); #1; n++; end
        check("reach_word6", 80'(served), 80'(7));
        busy = 1'b1;
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (enable !== 1'b0 || flash_clk !== 1'b0 || flash_cs_n !== 1'b0) bad++;
        end
        check("stall_hold", 80'(bad), 80'(0));
        check("stall_no_write", 80'(pulses), 80'(6));
        busy = 1'b0;

        // Run to completion.
        n = 0;
        while (!done && n < 10000) begin @(posedge clk); #1; n++; end
        check("done_run1", 80'({done, flash_cs_n, enable, write_type}), 80'({1'b1, 1'b1, 1'b0, 2'b00}));
        check("pulses_run1", 80'(pulses), 80'(64));
        check("sb_empty_run1", 80'(exp_q.size()), 80'(0));
        check("word_at_16", 80'({mem[19], mem[18], mem[17], mem[16]}), 80'(32'hD5B8A9C4));
        check("byte_at_17", 80'({24'h0, mem[17]}), 80'(32'h0000_00A9));
        check("image_run1", 80'(mem_errors()), 80'(0));

        // Reset during ReadData of word 10.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        while (pulses < 10 && n < 3000) begin @(posedge clk); #1; n++; end
        repeat (30) @(posedge clk);
        #1;
        check("mid_word10", 80'(pulses), 80'(10));
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", outs(), ResetOuts);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n = 0;
        while (!done && n < 10000) begin @(posedge clk); #1; n++; end
        check("done_run2", 80'({done, flash_cs_n}), 80'({1'b1, 1'b1}));
        check("pulses_run2", 80'(pulses), 80'(64));
        check("sb_empty_run2", 80'(exp_q.size()), 80'(0));
        check("image_run2", 80'(mem_errors()), 80'(0));

        // Four-byte transfer instance.
        check("small_done", 80'({s_done, s_flash_cs_n, s_enable}), 80'({1'b1, 1'b1, 1'b0}));
        check("small_pulses", 80'(s_pulses), 80'(1));
        check("small_write", 80'({s_last_wt, s_last_addr, s_last_data}),
              80'({2'b11, 32'h0, 32'hFFFF_FFFF}));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
